// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states,
// the running decision, and the decision-to-flags mapping.
package serial_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_GT = 2'd1,
        DEC_LT = 2'd2
    } dec_t;

    // Map a final decision onto one-hot {gt, eq, lt} result flags.
    function automatic logic [2:0] dec_to_flags(input dec_t d);
        logic [2:0] f;
        case (d)
            DEC_GT:  f = 3'b100;
            DEC_LT:  f = 3'b001;
            default: f = 3'b010;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_bit_cell.sv
// Combinational 1-bit comparator cell: reports a>b, a==b, a<b.
module bit_compare_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    // Pure combinational compare of one operand bit pair
    always_comb begin
        gt = a & ~b;
        eq = ~(a ^ b);
        lt = ~a & b;
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial WIDTH-bit unsigned magnitude comparator. Walks the operands
// MSB first through one bit_compare_cell; the first differing bit fixes
// the decision, and RUN always lasts WIDTH cycles for fixed latency.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(WIDTH - 1);

    state_t           state;
    dec_t             decision;
    logic [CNT_W-1:0] index;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             bit_gt;
    logic             bit_eq;
    logic             bit_lt;

    // Single cell sees the currently selected shadow bit pair
    bit_compare_cell u_cell (
        .a  (a_sh[index]),
        .b  (b_sh[index]),
        .gt (bit_gt),
        .eq (bit_eq),
        .lt (bit_lt)
    );

    // Control FSM with index counter, shadow operands and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            decision <= DEC_EQ;
            index    <= IDX_MSB;
            a_sh     <= '0;
            b_sh     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_gt_b   <= 1'b0;
            a_eq_b   <= 1'b0;
            a_lt_b   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh     <= a_in;
                        b_sh     <= b_in;
                        index    <= IDX_MSB;
                        decision <= DEC_EQ;
                        a_gt_b   <= 1'b0;
                        a_eq_b   <= 1'b0;
                        a_lt_b   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Only the first differing bit from the MSB may decide
                    if (decision == DEC_EQ && !bit_eq) begin
                        if (bit_gt)
                            decision <= DEC_GT;
                        else if (bit_lt)
                            decision <= DEC_LT;
                    end
                    if (index == '0)
                        state <= ST_DONE;
                    else
                        index <= index - 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b1;
                    {a_gt_b, a_eq_b, a_lt_b} <= dec_to_flags(decision);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: stimulus pushes expected {gt,eq,lt} into a queue and a
// negedge monitor pops and compares on every done pulse.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, done, a_gt_b, a_eq_b, a_lt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int t_start  = 0;
    int t_prev   = 0;
    logic [2:0] exp_q[$];

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: result checks on done, flags-clear checks while busy
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check("flags", int'({a_gt_b, a_eq_b, a_lt_b}), int'(e));
                    check("onehot", int'($countones({a_gt_b, a_eq_b, a_lt_b})), 1);
                end
            end
            if (busy)
                check("flags_clear_busy", int'({a_gt_b, a_eq_b, a_lt_b}), 0);
        end
    end

    // Issue one compare; optionally disturb inputs mid-run; check latency
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] exp_flags, input bit disturb);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        exp_q.push_back(exp_flags);
        @(posedge clk);
        t_prev  = t_start;
        t_start = cyc;
        #1 start = 1'b0;
        n = 0;
        while (n < 3 * WIDTH) begin
            if (disturb && n == 3) begin
                @(negedge clk);
                a_in = '1; start = 1'b1;
                @(posedge clk); n++;
                #1 start = 1'b0;
                if (done) break;
                continue;
            end
            @(posedge clk); n++;
            #1;
            if (done) break;
        end
        check("latency_edges", n, WIDTH + 1);
    endtask

    function automatic logic [2:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    initial begin
        // 1. reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", int'({a_gt_b, a_eq_b, a_lt_b}), 0);

        // 2. basic greater, flags hold afterwards
        run_cmp(8'h5A, 8'h3C, 3'b100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_flags", int'({a_gt_b, a_eq_b, a_lt_b}), 3'b100);
        check("hold_done", done, 0);
        check("hold_busy", busy, 0);

        // 3. LSB-only difference then all-ones equal, back-to-back
        run_cmp(8'h80, 8'h81, 3'b001, 1'b0);
        run_cmp(8'hFF, 8'hFF, 3'b010, 1'b0);
        check("start_to_start", t_start - t_prev, WIDTH + 2);

        // 4. inputs changed and start pulsed mid-run are ignored
        run_cmp(8'h00, 8'hFF, 3'b001, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("single_done", done_cnt, 4);

        // boundaries 0 vs 0, max vs 0
        run_cmp(8'h00, 8'h00, 3'b010, 1'b0);
        run_cmp(8'hFF, 8'h00, 3'b100, 1'b0);

        // 5. abort with reset in RUN cycle 4
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_flags", int'({a_gt_b, a_eq_b, a_lt_b}), 0);
        repeat (WIDTH + 4) @(posedge clk);
        #1 check("abort_no_done", done_cnt, 6);
        run_cmp(8'h10, 8'h01, 3'b100, 1'b0);

        // 6. random pairs vs golden
        for (int i = 0; i < 500; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = (i % 8 == 0) ? ra : WIDTH'($urandom);
            run_cmp(ra, rb, golden(ra, rb), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("done_total", done_cnt, 507);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
